pipe_stage_reg: RTL

- Parametrised, elastic pipeline-stage register for the RV32I core.
- Next generation of the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Adds:
  - valid/ready handshake for stall propagation
  - optional skid slot that breaks the ready path
  - synchronous flush
  - bubble masking of control bits
- Payload is split into data (never masked) and control (zeroed on bubble), so a bubble can never write the register file or memory.

---
 rtl/pipe_stage_reg.sv | 93 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with optional skid slot, flush and control masking.
module pipe_stage_reg #(
  parameter int DATA_W   = 128,
  parameter int CTRL_W   = 8,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKD = 2'd2} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic main_valid, skid_valid, in_x, out_x, load_main, load_skid, pop_skid;
  // state encoding doubles as the registered occupancy count
  assign main_valid  = state != EMPTY;
  assign skid_valid  = state == SKD;
  assign o_occupancy = state;
  assign o_ready     = (SKID != 0) ? !skid_valid : (!main_valid | i_ready);
  assign o_valid     = main_valid;
  assign o_data      = main_data;
  assign o_ctrl      = main_valid ? main_ctrl : '0;
  assign in_x        = i_valid & o_ready;
  assign out_x       = o_valid & i_ready;
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        state_nxt = in_x ? FULL : EMPTY;
        load_main = in_x;
      end
      FULL: begin
        load_main = in_x & out_x;
        load_skid = in_x & !out_x;
        state_nxt = (in_x & !out_x) ? SKD : (!in_x & out_x) ? EMPTY : FULL;
      end
      SKD: begin
        state_nxt = out_x ? FULL : SKD;
        pop_skid  = out_x;
      end
      default: state_nxt = EMPTY;
    endcase
    if (i_flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= EMPTY;
    else state <= state_nxt;
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (i_flush) begin
      if (CLR_DATA != 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main) begin
        main_data <= i_data;
        main_ctrl <= i_ctrl;
      end else if (pop_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= i_data;
        skid_ctrl <= i_ctrl;
      end
    end
  end
endmodule
